// File: rtl/bcd_display_scanner_if.sv
// rtl/bcd_display_scanner_if.sv - handshake input and display bus of the BCD display scanner
interface bcd_display_scanner_if;
  logic       in_valid;
  logic       in_ready;
  logic [0:7] in_bcd;
  logic [0:6] seg;
  logic [0:1] dig_en;
  logic       err;

  modport master (
    output in_valid,
    output in_bcd,
    input  in_ready,
    input  seg,
    input  dig_en,
    input  err
  );

  modport slave (
    input  in_valid,
    input  in_bcd,
    output in_ready,
    output seg,
    output dig_en,
    output err
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - latches a 2-digit BCD value and scans it tens/units onto a 7-segment bus
module bcd_display_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bcd_display_scanner_if.slave   bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, SCAN_HI, SCAN_LO} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [0:7]    r_h;
  logic [0:7]    w_h_nxt;
  logic [0:6]    r_seg;
  logic [0:6]    w_seg_nxt;
  logic [0:1]    r_dig_en;
  logic [0:1]    w_dig_en_nxt;
  logic          r_err;
  logic          w_err_nxt;
  logic          w_ready;
  logic          w_xfer;
  logic [3:0]    w_tens;
  logic [3:0]    w_units;

  function automatic logic [0:6] f_decode(input logic [3:0] n);
    case (n)
      4'd0:    f_decode = 7'b1111110;
      4'd1:    f_decode = 7'b0110000;
      4'd2:    f_decode = 7'b1101101;
      4'd3:    f_decode = 7'b1111001;
      4'd4:    f_decode = 7'b0110011;
      4'd5:    f_decode = 7'b1011011;
      4'd6:    f_decode = 7'b1011111;
      4'd7:    f_decode = 7'b1110000;
      4'd8:    f_decode = 7'b1111111;
      4'd9:    f_decode = 7'b1111011;
      default: f_decode = 7'b0000001;
    endcase
  endfunction

  // New values are only taken at a frame boundary so a digit pair never tears.
  assign w_ready = (r_state == IDLE) || ((r_state == SCAN_LO) && (r_cnt == '0));
  assign w_xfer  = bus.in_valid && w_ready;
  assign w_tens  = r_h[0:3];
  assign w_units = r_h[4:7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_h      <= 8'h00;
      r_seg    <= '0;
      r_dig_en <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_h      <= w_h_nxt;
      r_seg    <= w_seg_nxt;
      r_dig_en <= w_dig_en_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_h_nxt     = r_h;
    if (w_xfer) begin
      w_h_nxt = bus.in_bcd;
    end
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_state_nxt = SCAN_HI;
          w_cnt_nxt   = RELOAD;
        end
      end
      SCAN_HI: begin
        if (r_cnt == '0) begin
          w_state_nxt = SCAN_LO;
          w_cnt_nxt   = RELOAD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      SCAN_LO: begin
        if (r_cnt == '0) begin
          w_state_nxt = SCAN_HI;
          w_cnt_nxt   = RELOAD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Display registers follow the current state and hold value, one cycle behind.
  always_comb begin
    w_seg_nxt    = '0;
    w_dig_en_nxt = 2'b00;
    w_err_nxt    = (w_tens > 4'd9) || (w_units > 4'd9);
    case (r_state)
      SCAN_HI: begin
        if (!(BLANK_LZ && (w_tens == 4'd0))) begin
          w_seg_nxt    = f_decode(w_tens);
          w_dig_en_nxt = 2'b10;
        end
      end
      SCAN_LO: begin
        w_seg_nxt    = f_decode(w_units);
        w_dig_en_nxt = 2'b01;
      end
      default: begin
        w_seg_nxt    = '0;
        w_dig_en_nxt = 2'b00;
      end
    endcase
  end

  assign bus.in_ready = w_ready;
  assign bus.seg      = r_seg;
  assign bus.dig_en   = r_dig_en;
  assign bus.err      = r_err;

endmodule
